hilo_fwd_file: RTL and testbench

Parametrised HI/LO special-register file for the pipelined CPU core. It holds the architectural HI and LO registers and forwards pending writes from NUM_FWD in-flight pipeline stages plus writeback. It tracks one outstanding long-latency multiply/divide operation and requests a pipeline stall when a HI/LO access would read a result that is not yet available. Read data is registered into the ID→EX boundary, honouring the core's stall vector.

---
 rtl/hilo_fwd_file.sv | 162 ++++++++++++++++
 tb/tb_hilo_fwd_file.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_fwd_file.sv
// HI/LO special-register file with multi-stage write forwarding, a tracker for
// one outstanding multiply/divide, and an ID->EX read register that honours the stall vector.
module hilo_fwd_file #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall_id,
  input  logic                              stall_ex,
  input  logic [NUM_FWD*(2*DATA_W+2)-1:0]   fwd_bus,
  input  logic [2*DATA_W+1:0]               wb_bus,
  input  logic                              rd_req,
  input  logic                              md_start,
  input  logic                              md_cancel,
  input  logic                              md_done,
  input  logic [DATA_W-1:0]                 md_hi,
  input  logic [DATA_W-1:0]                 md_lo,
  output logic [DATA_W-1:0]                 hi_data,
  output logic [DATA_W-1:0]                 lo_data,
  output logic                              hilo_stall_req,
  output logic                              md_busy,
  output logic                              md_err
);

  localparam int BUS_W = 2*DATA_W + 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_reg;
  logic                md_busy_reg;
  logic                md_err_reg;

  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic [DATA_W-1:0]   hi_data_reg;
  logic [DATA_W-1:0]   lo_data_reg;

  logic [DATA_W-1:0]   hi_next;
  logic [DATA_W-1:0]   lo_next;
  logic [DATA_W-1:0]   hi_data_next;
  logic [DATA_W-1:0]   lo_data_next;

  logic                md_accept;

  logic                wb_hi_we;
  logic                wb_lo_we;
  logic [DATA_W-1:0]   wb_hi;
  logic [DATA_W-1:0]   wb_lo;

  logic [NUM_FWD-1:0]  slot_hi_we;
  logic [NUM_FWD-1:0]  slot_lo_we;
  logic [DATA_W-1:0]   slot_hi [NUM_FWD];
  logic [DATA_W-1:0]   slot_lo [NUM_FWD];

  // Split each forwarding slot into its {hi_we, lo_we, hi, lo} fields.
  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_slot
      assign slot_hi_we[gi] = fwd_bus[gi*BUS_W + BUS_W - 1];
      assign slot_lo_we[gi] = fwd_bus[gi*BUS_W + BUS_W - 2];
      assign slot_hi[gi]    = fwd_bus[gi*BUS_W + DATA_W +: DATA_W];
      assign slot_lo[gi]    = fwd_bus[gi*BUS_W +: DATA_W];
    end
  endgenerate

  assign wb_hi_we = wb_bus[BUS_W-1];
  assign wb_lo_we = wb_bus[BUS_W-2];
  assign wb_hi    = wb_bus[DATA_W +: DATA_W];
  assign wb_lo    = wb_bus[0 +: DATA_W];

  // A result is only real if an op is outstanding and it is not being flushed.
  assign md_accept = (state_reg == BUSY) & md_done & ~md_cancel;

  // Forward value: walk oldest to youngest so the youngest writer wins each half.
  always_comb begin
    hi_next = wb_hi_we ? wb_hi : hi_reg;
    lo_next = wb_lo_we ? wb_lo : lo_reg;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (slot_hi_we[k]) hi_next = slot_hi[k];
      if (slot_lo_we[k]) lo_next = slot_lo[k];
    end
    if (md_accept) begin
      hi_next = md_hi;
      lo_next = md_lo;
    end
  end

  // EX-side register: bubble when ID stalls but EX drains, hold when both stall.
  always_comb begin
    hi_data_next = hi_data_reg;
    lo_data_next = lo_data_reg;
    if (stall_id && !stall_ex) begin
      hi_data_next = '0;
      lo_data_next = '0;
    end else if (!stall_id) begin
      hi_data_next = hi_next;
      lo_data_next = lo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_data_reg <= '0;
      lo_data_reg <= '0;
    end else begin
      hi_data_reg <= hi_data_next;
      lo_data_reg <= lo_data_next;
    end
  end

  // Architectural commit: the long op is the younger instruction, so it beats writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (md_accept) begin
      hi_reg <= md_hi;
      lo_reg <= md_lo;
    end else begin
      if (wb_hi_we) hi_reg <= wb_hi;
      if (wb_lo_we) lo_reg <= wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      md_busy_reg <= 1'b0;
      md_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md_done) md_err_reg <= 1'b1;
          if (md_start) begin
            state_reg   <= BUSY;
            md_busy_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (md_start) md_err_reg <= 1'b1;
          if (md_cancel || md_done) begin
            state_reg   <= IDLE;
            md_busy_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  // A same-cycle md_start must stall too, otherwise the reader would bypass the long op.
  assign hilo_stall_req = rd_req & ~md_cancel &
                          (md_start | ((state_reg == BUSY) & ~md_done));

  assign hi_data = hi_data_reg;
  assign lo_data = lo_data_reg;
  assign md_busy = md_busy_reg;
  assign md_err  = md_err_reg;

endmodule

// File: tb/tb_hilo_fwd_file.sv
// Scoreboard bench for hilo_fwd_file: expected EX-side values are queued when driven
// and compared one cycle later, plus direct checks of stall, busy and error flags.
module tb_hilo_fwd_file;
  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;
  localparam int BUS_W   = 2*DATA_W + 2;

  logic                       clk;
  logic                       rst;
  logic                       stall_id;
  logic                       stall_ex;
  logic [BUS_W-1:0]           fwd0;
  logic [BUS_W-1:0]           fwd1;
  logic [NUM_FWD*BUS_W-1:0]   fwd_bus;
  logic [BUS_W-1:0]           wb_bus;
  logic                       rd_req;
  logic                       md_start;
  logic                       md_cancel;
  logic                       md_done;
  logic [DATA_W-1:0]          md_hi;
  logic [DATA_W-1:0]          md_lo;
  logic [DATA_W-1:0]          hi_data;
  logic [DATA_W-1:0]          lo_data;
  logic                       hilo_stall_req;
  logic                       md_busy;
  logic                       md_err;

  typedef struct {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  assign fwd_bus = {fwd1, fwd0};

  hilo_fwd_file #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .fwd_bus        (fwd_bus),
    .wb_bus         (wb_bus),
    .rd_req         (rd_req),
    .md_start       (md_start),
    .md_cancel      (md_cancel),
    .md_done        (md_done),
    .md_hi          (md_hi),
    .md_lo          (md_lo),
    .hi_data        (hi_data),
    .lo_data        (lo_data),
    .hilo_stall_req (hilo_stall_req),
    .md_busy        (md_busy),
    .md_err         (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] mk(input logic hwe, input logic lwe,
                                          input logic [DATA_W-1:0] h,
                                          input logic [DATA_W-1:0] l);
    return {hwe, lwe, h, l};
  endfunction

  task automatic idle_inputs();
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    fwd0      = '0;
    fwd1      = '0;
    wb_bus    = '0;
    rd_req    = 1'b0;
    md_start  = 1'b0;
    md_cancel = 1'b0;
    md_done   = 1'b0;
    md_hi     = '0;
    md_lo     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (md_busy !== 1'b0 || md_err !== 1'b0 || hilo_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b err=%b stall=%b required 0 0 0", md_busy, md_err, hilo_stall_req);
    end
    exp_q.push_back('{hi: 32'h0, lo: 32'h0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL reset_data: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    $display("reset: hi=%h lo=%h busy=%b err=%b", hi_data, lo_data, md_busy, md_err);
  endtask

  task automatic test_fwd_priority();
    fwd0   = mk(1'b1, 1'b0, 32'hA, 32'h77);
    fwd1   = mk(1'b1, 1'b1, 32'hB, 32'hC);
    wb_bus = mk(1'b1, 1'b1, 32'hD, 32'hE);
    exp_q.push_back('{hi: 32'hA, lo: 32'hC});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL fwd_priority: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    $display("fwd_priority: hi=%h lo=%h", hi_data, lo_data);
    idle_inputs();
    exp_q.push_back('{hi: 32'hD, lo: 32'hE});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL wb_commit: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    $display("wb_commit: hi=%h lo=%h", hi_data, lo_data);
  endtask

  task automatic test_long_op();
    stall_id = 1'b1;
    stall_ex = 1'b1;
    rd_req   = 1'b1;
    md_start = 1'b1;
    #1;
    checks++;
    if (hilo_stall_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_on_start: got %b required 1", hilo_stall_req);
    end
    tick();
    md_start = 1'b0;
    #1;
    checks++;
    if (hilo_stall_req !== 1'b1 || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy: got stall=%b busy=%b required 1 1", hilo_stall_req, md_busy);
    end
    tick();
    checks++;
    if (hilo_stall_req !== 1'b1 || hi_data !== 32'hD || lo_data !== 32'hE) begin
      errors++;
      $display("FAIL stall_hold: got stall=%b hi=%h lo=%h required 1 d e", hilo_stall_req, hi_data, lo_data);
    end
    stall_id = 1'b0;
    stall_ex = 1'b0;
    md_done  = 1'b1;
    md_hi    = 32'h1234;
    md_lo    = 32'h5678;
    wb_bus   = mk(1'b1, 1'b0, 32'h9, 32'h0);
    #1;
    checks++;
    if (hilo_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got %b required 0", hilo_stall_req);
    end
    exp_q.push_back('{hi: 32'h1234, lo: 32'h5678});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_done_fwd: got hi=%h lo=%h busy=%b required hi=%h lo=%h busy=0", hi_data, lo_data, md_busy, e.hi, e.lo);
    end
    $display("long_op: hi=%h lo=%h busy=%b", hi_data, lo_data, md_busy);
    idle_inputs();
    exp_q.push_back('{hi: 32'h1234, lo: 32'h5678});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL md_commit: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
  endtask

  task automatic test_cancel();
    md_start = 1'b1;
    tick();
    md_start  = 1'b0;
    md_cancel = 1'b1;
    md_done   = 1'b1;
    md_hi     = 32'hFF;
    md_lo     = 32'hEE;
    exp_q.push_back('{hi: 32'h1234, lo: 32'h5678});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo || md_busy !== 1'b0 || md_err !== 1'b0) begin
      errors++;
      $display("FAIL cancel: got hi=%h lo=%h busy=%b err=%b required hi=%h lo=%h busy=0 err=0", hi_data, lo_data, md_busy, md_err, e.hi, e.lo);
    end
    md_cancel = 1'b0;
    md_done   = 1'b0;
    exp_q.push_back('{hi: 32'h1234, lo: 32'h5678});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL cancel_nowrite: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    md_done = 1'b1;
    exp_q.push_back('{hi: 32'h1234, lo: 32'h5678});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (md_err !== 1'b1 || hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL stray_done: got err=%b hi=%h lo=%h required err=1 hi=%h lo=%h", md_err, hi_data, lo_data, e.hi, e.lo);
    end
    md_done = 1'b0;
    tick();
    tick();
    checks++;
    if (md_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", md_err);
    end
    $display("cancel: busy=%b err=%b", md_busy, md_err);
    idle_inputs();
  endtask

  task automatic test_stall_vector();
    fwd0 = mk(1'b1, 1'b1, 32'h11, 32'h22);
    exp_q.push_back('{hi: 32'h11, lo: 32'h22});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL stall_load: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    stall_id = 1'b1;
    exp_q.push_back('{hi: 32'h0, lo: 32'h0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL bubble: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    stall_id = 1'b0;
    exp_q.push_back('{hi: 32'h11, lo: 32'h22});
    tick();
    e = exp_q.pop_front();
    stall_id = 1'b1;
    stall_ex = 1'b1;
    fwd0     = mk(1'b1, 1'b1, 32'h33, 32'h44);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (hi_data !== e.hi || lo_data !== e.lo) begin
        errors++;
        $display("FAIL hold_%0d: got hi=%h lo=%h required hi=%h lo=%h", i, hi_data, lo_data, e.hi, e.lo);
      end
    end
    $display("stall_vector: hi=%h lo=%h", hi_data, lo_data);
    idle_inputs();
  endtask

  task automatic test_rst_busy();
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (md_busy !== 1'b0 || md_err !== 1'b0 || hi_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy: got busy=%b err=%b hi=%h required 0 0 0", md_busy, md_err, hi_data);
    end
    exp_q.push_back('{hi: 32'h0, lo: 32'h0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo) begin
      errors++;
      $display("FAIL rst_regs: got hi=%h lo=%h required hi=%h lo=%h", hi_data, lo_data, e.hi, e.lo);
    end
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    checks++;
    if (md_busy !== 1'b1 || md_err !== 1'b0) begin
      errors++;
      $display("FAIL restart: got busy=%b err=%b required 1 0", md_busy, md_err);
    end
    md_done = 1'b1;
    md_hi   = 32'hAA;
    md_lo   = 32'hBB;
    exp_q.push_back('{hi: 32'hAA, lo: 32'hBB});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (hi_data !== e.hi || lo_data !== e.lo || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got hi=%h lo=%h busy=%b required hi=%h lo=%h busy=0", hi_data, lo_data, md_busy, e.hi, e.lo);
    end
    md_done  = 1'b0;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    rst      = 1'b1;
    tick();
    rst     = 1'b0;
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    checks++;
    if (md_err !== 1'b1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done: got err=%b busy=%b required 1 0", md_err, md_busy);
    end
    $display("rst_busy: busy=%b err=%b", md_busy, md_err);
    idle_inputs();
  endtask

  // Random forwarding and stall traffic checked against a small reference model.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] m_hi, m_lo, f_hi, f_lo, o_hi, o_lo;
    logic [BUS_W-1:0]  s [3];
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    o_hi = '0;
    o_lo = '0;
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 3; j++)
        s[j] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      fwd0     = s[0];
      fwd1     = s[1];
      wb_bus   = s[2];
      stall_id = ($urandom_range(0, 3) == 0);
      stall_ex = 1'($urandom_range(0, 1));
      f_hi = s[2][BUS_W-1] ? s[2][2*DATA_W-1:DATA_W] : m_hi;
      f_lo = s[2][BUS_W-2] ? s[2][DATA_W-1:0]        : m_lo;
      if (s[1][BUS_W-1]) f_hi = s[1][2*DATA_W-1:DATA_W];
      if (s[1][BUS_W-2]) f_lo = s[1][DATA_W-1:0];
      if (s[0][BUS_W-1]) f_hi = s[0][2*DATA_W-1:DATA_W];
      if (s[0][BUS_W-2]) f_lo = s[0][DATA_W-1:0];
      if (stall_id && !stall_ex) begin
        o_hi = '0;
        o_lo = '0;
      end else if (!stall_id) begin
        o_hi = f_hi;
        o_lo = f_lo;
      end
      if (s[2][BUS_W-1]) m_hi = s[2][2*DATA_W-1:DATA_W];
      if (s[2][BUS_W-2]) m_lo = s[2][DATA_W-1:0];
      exp_q.push_back('{hi: o_hi, lo: o_lo});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (hi_data !== e.hi || lo_data !== e.lo) begin
        errors++;
        $display("FAIL b2b_%0d: got hi=%h lo=%h required hi=%h lo=%h", i, hi_data, lo_data, e.hi, e.lo);
      end
      $display("b2b %0d: sid=%b sex=%b hi=%h lo=%h", i, stall_id, stall_ex, hi_data, lo_data);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_long_op();
    test_cancel();
    test_stall_vector();
    test_rst_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
